fft_bitrev_reorder: RTL and testbench

- Output reorder buffer at the tail of the 512-point, 16-lane pipelined FFT.
- The last butterfly/twiddle stage emits each frame in bit-reversed index order as 32 consecutive 16-lane words. This block collects a full frame into one bank of a ping-pong buffer, then reads it back in natural index order on the same 16-lane interface.
- While one bank drains, the other bank fills, so back-to-back frames stream with no stall.

---
 rtl/fft_bitrev_reorder.sv | 170 +++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Output reorder buffer for the tail of a pipelined multi-lane FFT. Frames
// arrive in bit-reversed index order as BEATS words of LANES samples. Each
// frame is collected into one bank of a ping-pong buffer and is then read back
// in natural index order. The other bank fills while one bank drains, so
// back-to-back frames stream with no stall.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   din_re/im   [0:LANES-1] signed samples, bit-reversed stream order
//   din_valid   input beat qualifier (gaps allowed)
//   dout_re/im  [0:LANES-1] signed samples, natural order (0 when not valid)
//   dout_valid  output beat qualifier
//   dout_last   high on the final beat of each output frame
//
// Latency: if the last input beat of a frame is sampled at edge E, the first
// output beat is driven from edge E+2.
// ---------------------------------------------------------------------------
module fft_bitrev_reorder #(
  parameter int WIDTH = 16,
  parameter int N     = 512,
  parameter int LANES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] din_re [0:LANES-1],
  input  logic signed [WIDTH-1:0] din_im [0:LANES-1],
  input  logic                    din_valid,
  output logic signed [WIDTH-1:0] dout_re [0:LANES-1],
  output logic signed [WIDTH-1:0] dout_im [0:LANES-1],
  output logic                    dout_valid,
  output logic                    dout_last
);

  localparam int LOG2N = $clog2(N);
  localparam int LOG2L = $clog2(LANES);
  localparam int LOG2B = LOG2N - LOG2L;
  localparam int BEATS = N / LANES;
  localparam logic [LOG2B-1:0] LAST_BEAT = LOG2B'(BEATS - 1);

  typedef enum logic {IDLE, READ} state_t;

  // Bank select is the MSB of the buffer address.
  logic signed [WIDTH-1:0] mem_re [0:2*N-1];
  logic signed [WIDTH-1:0] mem_im [0:2*N-1];

  logic [LOG2B-1:0] wcnt_q;
  logic             wbank_q;
  logic             req_q;      // a full bank is waiting to be drained
  logic             frame_done;
  logic             consume;

  state_t           state_q, state_d;
  logic [LOG2B-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;

  logic [LOG2N-1:0] wr_addr [0:LANES-1];

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

  // Stream index of lane l in beat wcnt is {wcnt, l}; it lands at its
  // bit-reversed (natural) address.
  always_comb begin
    for (int l = 0; l < LANES; l++) wr_addr[l] = bitrev({wcnt_q, LOG2L'(l)});
  end

  assign frame_done = din_valid && (wcnt_q == LAST_BEAT);

  // NOTE: buffer storage has no reset; contents are only ever read after a
  // complete frame has been written, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (din_valid) begin
      for (int l = 0; l < LANES; l++) begin
        mem_re[{wbank_q, wr_addr[l]}] <= din_re[l];
        mem_im[{wbank_q, wr_addr[l]}] <= din_im[l];
      end
    end
  end

  // NOTE: all clocked state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      if (din_valid) wcnt_q <= wcnt_q + 1'b1;  // wraps at BEATS
      if (frame_done) wbank_q <= ~wbank_q;
      // A completing frame wins over a consume on the same edge.
      req_q <= frame_done | (req_q & ~consume);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    consume = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_q) begin
          state_d = READ;
          rcnt_d  = '0;
          rbank_d = ~wbank_q;  // write bank has already toggled away
          consume = 1'b1;
        end
      end
      READ: begin
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == LAST_BEAT) begin
          rcnt_d = '0;
          if (req_q) begin
            rbank_d = ~rbank_q;  // seamless switch to the other bank
            consume = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered output stage; data is forced to zero outside valid beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      for (int j = 0; j < LANES; j++) begin
        dout_re[j] <= '0;
        dout_im[j] <= '0;
      end
    end else begin
      dout_valid <= (state_q == READ);
      dout_last  <= (state_q == READ) && (rcnt_q == LAST_BEAT);
      for (int j = 0; j < LANES; j++) begin
        if (state_q == READ) begin
          dout_re[j] <= mem_re[{rbank_q, rcnt_q, LOG2L'(j)}];
          dout_im[j] <= mem_im[{rbank_q, rcnt_q, LOG2L'(j)}];
        end else begin
          dout_re[j] <= '0;
          dout_im[j] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft_bitrev_reorder
//
// Directed bench for fft_bitrev_reorder at default parameters (16-bit,
// 512 points, 16 lanes). Output beats are captured on the falling edge with
// the cycle number, then compared against values computed from the natural
// index of each sample.
// ---------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

  localparam int WIDTH = 16;
  localparam int LANES = 16;
  localparam int BEATS = 32;
  localparam int CAPN  = 512;

  localparam int K_RAMP = 0;
  localparam int K_SPOT = 1;
  localparam int K_EXT  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [WIDTH-1:0] din_re [0:LANES-1];
  logic signed [WIDTH-1:0] din_im [0:LANES-1];
  logic                    din_valid;
  logic signed [WIDTH-1:0] dout_re [0:LANES-1];
  logic signed [WIDTH-1:0] dout_im [0:LANES-1];
  logic                    dout_valid;
  logic                    dout_last;

  fft_bitrev_reorder dut (
    .clk        (clk),
    .rst        (rst),
    .din_re     (din_re),
    .din_im     (din_im),
    .din_valid  (din_valid),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid),
    .dout_last  (dout_last)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output capture
  logic signed [WIDTH-1:0] cap_re [0:CAPN-1][0:LANES-1];
  logic signed [WIDTH-1:0] cap_im [0:CAPN-1][0:LANES-1];
  logic                    cap_last [0:CAPN-1];
  int                      cap_cyc  [0:CAPN-1];
  int                      ncap = 0;

  always @(negedge clk) begin
    if (dout_valid === 1'b1 && ncap < CAPN) begin
      for (int j = 0; j < LANES; j++) begin
        cap_re[ncap][j] = dout_re[j];
        cap_im[ncap][j] = dout_im[j];
      end
      cap_last[ncap] = dout_last;
      cap_cyc[ncap]  = cyc;
      ncap = ncap + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs,
             $signed(exp), exp);
    end
  endtask

  function automatic int bitrev9(input int k);
    int r = 0;
    for (int i = 0; i < 9; i++) if (((k >> i) & 1) == 1) r |= (1 << (8 - i));
    return r;
  endfunction

  // Input sample for stream index k = c*LANES + l
  function automatic int in_re(input int kind, input int off, input int c, input int l);
    case (kind)
      K_RAMP:  return off + bitrev9(c * LANES + l);
      K_SPOT:  return (c == 0 && l == 1) ? 'h123 : 0;
      default: return (l % 2 == 0) ? 32767 : -32768;
    endcase
  endfunction

  function automatic int in_im(input int kind, input int c, input int l);
    case (kind)
      K_RAMP:  return -bitrev9(c * LANES + l);
      K_SPOT:  return 0;
      default: return (l % 2 == 0) ? -32768 : 32767;
    endcase
  endfunction

  // Expected output for natural index n
  function automatic int exp_re(input int kind, input int off, input int n);
    case (kind)
      K_RAMP:  return off + n;
      K_SPOT:  return (n == 256) ? 'h123 : 0;
      default: return ((bitrev9(n) & 15) % 2 == 0) ? 32767 : -32768;
    endcase
  endfunction

  function automatic int exp_im(input int kind, input int n);
    case (kind)
      K_RAMP:  return -n;
      K_SPOT:  return 0;
      default: return ((bitrev9(n) & 15) % 2 == 0) ? -32768 : 32767;
    endcase
  endfunction

  task automatic drive_beat(input int kind, input int off, input int c, output int edge_no);
    @(negedge clk);
    din_valid = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      din_re[l] = 16'(in_re(kind, off, c, l));
      din_im[l] = 16'(in_im(kind, c, l));
    end
    edge_no = cyc + 1;
  endtask

  task automatic drive_idle(input logic [15:0] junk);
    @(negedge clk);
    din_valid = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      din_re[l] = junk;
      din_im[l] = ~junk;
    end
  endtask

  task automatic drive_frame(input int kind, input int off, input bit gapped, output int last_edge);
    for (int c = 0; c < BEATS; c++) begin
      drive_beat(kind, off, c, last_edge);
      if (gapped && c < BEATS - 1) drive_idle(16'h5A5A);
    end
  endtask

  task automatic wait_out(input string tag, input int target);
    int t = 0;
    while (ncap < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (8) @(negedge clk);
    chk(tag, ncap, target);
  endtask

  task automatic check_frame(input string tag, input int base, input int first, input int kind,
                             input int off);
    for (int m = 0; m < BEATS; m++) begin
      chk($sformatf("%s_cyc[%0d]", tag, m), cap_cyc[base+m], first + m);
      chk($sformatf("%s_last[%0d]", tag, m), 32'(cap_last[base+m]), 32'(m == BEATS - 1));
      for (int j = 0; j < LANES; j++) begin
        chk($sformatf("%s_re[%0d][%0d]", tag, m, j), 32'(cap_re[base+m][j]),
            exp_re(kind, off, m * LANES + j));
        chk($sformatf("%s_im[%0d][%0d]", tag, m, j), 32'(cap_im[base+m][j]),
            exp_im(kind, m * LANES + j));
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    logic any_nz = 1'b0;
    for (int j = 0; j < LANES; j++) any_nz |= (dout_re[j] != 0) || (dout_im[j] != 0);
    chk({tag, "_valid"}, 32'(dout_valid), 0);
    chk({tag, "_last"}, 32'(dout_last), 0);
    chk({tag, "_data"}, 32'(any_nz), 0);
  endtask

  int base, le, le0, le1, le2, nlast;

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      din_re[l] = '0;
      din_im[l] = '0;
    end

    // Reset state
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Ramp frame
    base = ncap;
    drive_frame(K_RAMP, 0, 1'b0, le);
    drive_idle(16'h0000);
    wait_out("ramp_count", base + BEATS);
    check_frame("ramp", base, le + 2, K_RAMP, 0);

    // Spot value: bitrev9(1) = 256 -> beat 16 lane 0
    base = ncap;
    drive_frame(K_SPOT, 0, 1'b0, le);
    drive_idle(16'h0000);
    wait_out("spot_count", base + BEATS);
    check_frame("spot", base, le + 2, K_SPOT, 0);

    // Back-to-back: three frames with din_valid held high
    base = ncap;
    drive_frame(K_RAMP, 0, 1'b0, le0);
    drive_frame(K_RAMP, 1000, 1'b0, le1);
    drive_frame(K_RAMP, 2000, 1'b0, le2);
    drive_idle(16'h0000);
    wait_out("b2b_count", base + 3 * BEATS);
    check_frame("b2b0", base, le0 + 2, K_RAMP, 0);
    check_frame("b2b1", base + BEATS, le1 + 2, K_RAMP, 1000);
    check_frame("b2b2", base + 2 * BEATS, le2 + 2, K_RAMP, 2000);
    chk("b2b_contig", cap_cyc[base+3*BEATS-1] - cap_cyc[base], 3 * BEATS - 1);
    nlast = 0;
    for (int b = base; b < base + 3 * BEATS; b++) nlast += int'(cap_last[b]);
    chk("b2b_last_pulses", nlast, 3);

    // Gapped input: valid every other cycle, junk on idle cycles
    base = ncap;
    drive_frame(K_RAMP, 0, 1'b1, le);
    drive_idle(16'h0000);
    wait_out("gap_count", base + BEATS);
    check_frame("gap", base, le + 2, K_RAMP, 0);

    // Reset mid-operation: frame P draining while frame A is at beat 20
    drive_frame(K_RAMP, 0, 1'b0, le);
    for (int c = 0; c < 20; c++) drive_beat(K_RAMP, 3000, c, le);
    drive_beat(K_RAMP, 3000, 20, le);
    chk("pre_rst_valid", 32'(dout_valid), 1);
    #1 rst = 1'b1;
    din_valid = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    repeat (3) @(negedge clk);
    check_outputs_zero("rst_held");
    rst  = 1'b0;
    base = ncap;
    repeat (50) @(negedge clk);
    chk("rst_no_frame_a", ncap, base);
    drive_frame(K_RAMP, 500, 1'b0, le);
    drive_idle(16'h0000);
    wait_out("rst_b_count", base + BEATS);
    check_frame("rst_b", base, le + 2, K_RAMP, 500);

    // Extremes: 0x7FFF / 0x8000 alternating by input lane
    base = ncap;
    drive_frame(K_EXT, 0, 1'b0, le);
    drive_idle(16'h0000);
    wait_out("ext_count", base + BEATS);
    check_frame("ext", base, le + 2, K_EXT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
